// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and ARF control codes for the fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_REQ_HI,
    ST_VALID,
    ST_FAULT
  } state_t;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  localparam logic [3:0] RS_PC     = 4'b0001;
  localparam logic [3:0] RS_PCPAST = 4'b0010;
  localparam logic [3:0] RS_SP     = 4'b0100;
  localparam logic [3:0] RS_AR     = 4'b1000;

  localparam logic [1:0] SEL_AR     = 2'b00;
  localparam logic [1:0] SEL_SP     = 2'b01;
  localparam logic [1:0] SEL_PCPAST = 2'b10;
  localparam logic [1:0] SEL_PC     = 2'b11;

endpackage

// File: rtl/fetch_timeout.sv
// rtl/fetch_timeout.sv - memory wait counter; expires on the cycle the count would reach TIMEOUT_CYCLES
module fetch_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wait_cnt;

  // Any cycle without a wait is a state change or a capture, so the count restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!i_wait) begin
      r_wait_cnt <= '0;
    end else if (!o_expired) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_expired = i_wait && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - two-byte instruction fetch driving the ARF PC increment and decoder handshake
// Optional memory timeout with sticky fault: define FETCH_SEQ_TIMEOUT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 flush,
  input  logic                 mem_ready,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_re,
  output logic [1:0]           arf_out_a_sel,
  output logic [1:0]           arf_out_b_sel,
  output logic [3:0]           arf_r_sel,
  output logic [1:0]           arf_funsel,
  output logic [15:0]          ir,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic                 busy,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t               r_state;
  logic [15:0]          r_ir;
  logic                 r_ir_valid;
  logic                 r_mem_re;
  logic                 r_halt_pend;
  logic                 r_fault;
  logic [CNT_WIDTH-1:0] r_count;

  logic w_in_req;
  logic w_take;
  logic w_timeout;

  assign w_in_req = (r_state == ST_REQ_LO) || (r_state == ST_REQ_HI);
  assign w_take   = w_in_req && mem_ready && !flush;

`ifdef FETCH_SEQ_TIMEOUT_EN
  fetch_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wait   (w_in_req && !mem_ready && !flush),
    .o_expired(w_timeout)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_mem_re    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_fault     <= 1'b0;
      r_count     <= '0;
    end else begin
      if (halt && (r_state != ST_IDLE) && (r_state != ST_FAULT)) begin
        r_halt_pend <= 1'b1;
      end
      // Branch taken: restart from the (already redirected) PC, dropping any partial word
      if (flush && (r_state != ST_IDLE) && (r_state != ST_FAULT)) begin
        r_state     <= ST_REQ_LO;
        r_mem_re    <= 1'b1;
        r_ir_valid  <= 1'b0;
        r_ir        <= '0;
        r_halt_pend <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state  <= ST_REQ_LO;
              r_mem_re <= 1'b1;
            end
          end
          ST_REQ_LO: begin
            if (w_timeout) begin
              r_state  <= ST_FAULT;
              r_mem_re <= 1'b0;
              r_fault  <= 1'b1;
            end else if (mem_ready) begin
              r_ir[7:0] <= mem_rdata;
              r_state   <= ST_REQ_HI;
            end
          end
          ST_REQ_HI: begin
            if (w_timeout) begin
              r_state  <= ST_FAULT;
              r_mem_re <= 1'b0;
              r_fault  <= 1'b1;
            end else if (mem_ready) begin
              r_ir[15:8] <= mem_rdata;
              r_state    <= ST_VALID;
              r_mem_re   <= 1'b0;
              r_ir_valid <= 1'b1;
            end
          end
          ST_VALID: begin
            if (ir_ready) begin
              r_count     <= r_count + 1'b1;
              r_ir_valid  <= 1'b0;
              r_halt_pend <= 1'b0;
              if (halt || r_halt_pend) begin
                r_state  <= ST_IDLE;
                r_mem_re <= 1'b0;
              end else begin
                r_state  <= ST_REQ_LO;
                r_mem_re <= 1'b1;
              end
            end
          end
          ST_FAULT: begin
            r_mem_re <= 1'b0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_mem_re <= 1'b0;
          end
        endcase
      end
    end
  end

  assign arf_out_a_sel = SEL_PC;
  assign arf_out_b_sel = SEL_AR;
  assign arf_r_sel     = w_take ? RS_PC : 4'b0000;
  assign arf_funsel    = w_take ? FS_INC : FS_CLR;
  assign mem_re        = r_mem_re;
  assign ir            = r_ir;
  assign ir_valid      = r_ir_valid;
  assign busy          = (r_state != ST_IDLE);
  assign fault         = r_fault;
  assign instr_count   = r_count;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control stage directly upstream of the address register file (ARF), which holds PC, AR, SP and PC_past. It drives the ARF select and function lines so that PC appears on ARF out_a as the memory address. It fetches a 16-bit instruction as two byte reads over a ready-handshaked memory port and increments PC after each byte. The assembled instruction goes to the decoder through a valid/ready handshake.

Parameters:
CNT_WIDTH, 16, width of retired-instruction counter
TIMEOUT_CYCLES, 15, memory wait limit, used only when FETCH_SEQ_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
halt  in  1  return to IDLE after the current handshake
flush  in  1  abort the in-flight fetch (branch taken)
mem_ready  in  1  memory has valid mem_rdata this cycle
mem_rdata  in  8  memory read byte
mem_re  out  1  memory read request; address is ARF out_a
arf_out_a_sel  out  2  ARF out_a select
arf_out_b_sel  out  2  ARF out_b select
arf_r_sel  out  4  ARF enables {AR,SP,PC_past,PC}, active-high
arf_funsel  out  2  ARF function: 00 clear, 01 load, 10 decrement, 11 increment
ir  out  16  assembled instruction, {hi byte, lo byte}
ir_valid  out  1  ir holds a complete instruction
ir_ready  in  1  decoder accepts ir
busy  out  1  state is not IDLE
fault  out  1  memory timeout flag (0 when the feature is absent)
instr_count  out  CNT_WIDTH  number of completed ir handshakes

Behaviour:
- Async reset (rst_n=0):
  - state=IDLE; ir=0; ir_valid=0; mem_re=0.
  - arf_r_sel=0000; arf_funsel=00.
  - arf_out_a_sel=11 (PC); arf_out_b_sel=00 (AR).
  - instr_count=0; fault=0.
- Reset mid-fetch discards any partial ir and issues no PC update.
- arf_out_a_sel is held at 11 in every state; arf_out_b_sel is held at 00.
- States: IDLE, REQ_LO, REQ_HI, VALID, FAULT.
- IDLE: mem_re=0. start=1 -> REQ_LO.
- REQ_LO:
  - mem_re=1.
  - On an edge with mem_ready=1: ir[7:0]<=mem_rdata, then -> REQ_HI.
  - In that same cycle, combinationally drive arf_r_sel=0001 and arf_funsel=11 (single PC increment).
- REQ_HI: same as REQ_LO, but captures ir[15:8] and then -> VALID.
- PC increment rule: arf_r_sel is non-zero only in the mem_ready cycle, so exactly one increment per byte and two per instruction. In all other cycles arf_r_sel=0000.
- Latency: minimum 2 cycles from REQ_LO entry to ir_valid=1 (mem_ready constantly high).
- VALID:
  - mem_re=0; ir_valid=1; ir is stable while ir_ready=0.
  - On ir_ready=1: instr_count increments, wrapping modulo 2^CNT_WIDTH.
  - Next state after ir_ready: -> IDLE if halt=1, else -> REQ_LO (back-to-back fetch, no bubble beyond the memory latency).
- halt outside VALID: held pending (registered), then applied at the next VALID handshake.
- flush=1 (highest priority, any state except IDLE/FAULT):
  - Next state REQ_LO; ir_valid<=0; ir<=0.
  - No PC increment that cycle, even if mem_ready=1.
  - Pending halt is cleared.
- flush in IDLE is ignored.
- start outside IDLE is ignored.
- Simultaneous ir_ready and flush in VALID: flush wins; instr_count does not increment.
- busy = (state != IDLE).

Optional Feature:
Macro FETCH_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every state entry and counts cycles in REQ_LO/REQ_HI while mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES: -> FAULT, mem_re=0, fault=1.
  - fault is sticky; only rst_n clears it. FAULT ignores start and flush.
- Undefined: no counter, no FAULT state; the sequencer waits indefinitely; fault tied to 0.

Decomposition:
- Package fetch_pkg holds:
  - State enum.
  - funsel constants: FS_CLR=00, FS_LOAD=01, FS_DEC=10, FS_INC=11.
  - r_sel one-hot constants: RS_PC=0001, RS_PCPAST=0010, RS_SP=0100, RS_AR=1000.
  - out select codes: SEL_AR=00, SEL_SP=01, SEL_PCPAST=10, SEL_PC=11.
- One natural sub-module: fetch_timeout (wait counter plus compare). It is instantiated only under FETCH_SEQ_TIMEOUT_EN.

Test Plan:
- Reset then start=1, mem_ready=1, mem_rdata=0x34 then 0x12, ir_ready=0 -> ir_valid=1 two cycles after REQ_LO entry; ir=0x1234; exactly two cycles show arf_r_sel=0001 with arf_funsel=11.
- mem_ready low for 3 cycles per byte -> arf_r_sel=0000 during the waits; ir_valid appears 8 cycles after REQ_LO entry; ir correct.
- Back-to-back: ir_ready=1 in VALID, 5 instructions -> instr_count=5; mem_re reasserts the cycle after each handshake.
- flush=1 in REQ_HI with mem_ready=1 -> no PC increment that cycle, ir=0, next state REQ_LO; a new 0xBEEF fetch completes cleanly.
- halt=1 asserted during REQ_LO -> instruction completes; after the ir_ready handshake, busy=0 and mem_re=0.
- With FETCH_SEQ_TIMEOUT_EN, mem_ready=0 for 15 cycles -> fault=1, mem_re=0; start is ignored; rst_n=0 clears fault.
